// File: rtl/rca_wb_serializer.sv
// rca_wb_serializer
//   Buffers RCA writeback bundles in a small circular FIFO and drains the head
//   bundle into a single register-file write port, one write per cycle, in
//   ascending port order. A one-cycle done pulse is issued when a bundle retires.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           discard every buffered bundle
//   in_valid/ready  bundle handshake; in_id, in_rd, in_rd_addr, in_port_en payload
//   rf_we/ready     register write handshake; rf_addr, rf_data, rf_id payload
//   done_valid      head bundle retired this cycle; done_id its id
//   busy            FIFO holds at least one bundle
module rca_wb_serializer #(
  parameter int NUM_WRITE_PORTS = 5,
  parameter int XLEN            = 32,
  parameter int ID_W            = 3,
  parameter int DEPTH           = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ID_W-1:0]              in_id,
  input  logic [NUM_WRITE_PORTS*XLEN-1:0] in_rd,
  input  logic [NUM_WRITE_PORTS*5-1:0] in_rd_addr,
  input  logic [NUM_WRITE_PORTS-1:0]   in_port_en,
  output logic                         rf_we,
  input  logic                         rf_ready,
  output logic [4:0]                   rf_addr,
  output logic [XLEN-1:0]              rf_data,
  output logic [ID_W-1:0]              rf_id,
  output logic                         done_valid,
  output logic [ID_W-1:0]              done_id,
  output logic                         busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [NUM_WRITE_PORTS-1:0] mask_t;

  logic [ID_W-1:0]                 r_id   [DEPTH];
  logic [NUM_WRITE_PORTS*XLEN-1:0] r_data [DEPTH];
  logic [NUM_WRITE_PORTS*5-1:0]    r_addr [DEPTH];
  mask_t                           r_mask [DEPTH];

  logic [AW-1:0] r_rptr, r_wptr;
  logic [CW-1:0] r_count;

  logic            w_kill, w_nonempty, w_push, w_fire, w_last, w_found;
  mask_t           w_head_mask, w_sel_oh, w_nz;
  logic [4:0]      w_sel_addr;
  logic [XLEN-1:0] w_sel_data;

  assign w_kill      = rst | flush;
  assign w_nonempty  = (r_count != '0);
  assign w_head_mask = r_mask[r_rptr];

  // Lowest pending port wins, so duplicate addresses land in ascending port order.
  always_comb begin
    w_found    = 1'b0;
    w_sel_oh   = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_nz       = '0;
    for (int unsigned i = 0; i < NUM_WRITE_PORTS; i++) begin
      w_nz[i] = (in_rd_addr[i*5 +: 5] != 5'd0);
      if (w_nonempty && w_head_mask[i] && !w_found) begin
        w_found    = 1'b1;
        w_sel_oh   = mask_t'(1) << i;
        w_sel_addr = r_addr[r_rptr][i*5 +: 5];
        w_sel_data = r_data[r_rptr][i*XLEN +: XLEN];
      end
    end
  end

  // Exactly one bit left in the head mask.
  assign w_last = ((w_head_mask & (w_head_mask - mask_t'(1))) == '0);

  assign in_ready   = (r_count != CW'(DEPTH)) && !flush;
  assign w_push     = in_valid && in_ready;
  assign rf_we      = !w_kill && w_found;
  assign w_fire     = rf_we && rf_ready;
  // An empty-mask head retires immediately without waiting for rf_ready.
  assign done_valid = !w_kill && w_nonempty && (!(|w_head_mask) || (w_fire && w_last));
  assign rf_addr    = w_sel_addr;
  assign rf_data    = w_sel_data;
  assign rf_id      = w_found ? r_id[r_rptr] : '0;
  assign done_id    = done_valid ? r_id[r_rptr] : '0;
  assign busy       = w_nonempty;

  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)     r_wptr <= r_wptr + 1'b1;
      if (done_valid) r_rptr <= r_rptr + 1'b1;
      if (w_push && !done_valid)      r_count <= r_count + CW'(1);
      else if (!w_push && done_valid) r_count <= r_count - CW'(1);
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!w_kill) begin
      if (w_fire) r_mask[r_rptr] <= w_head_mask & ~w_sel_oh;
      if (w_push) begin
        r_id[r_wptr]   <= in_id;
        r_data[r_wptr] <= in_rd;
        r_addr[r_wptr] <= in_rd_addr;
        r_mask[r_wptr] <= in_port_en & w_nz;
      end
    end
  end

endmodule

// File: tb/tb_rca_wb_serializer.sv
module tb_rca_wb_serializer;
  localparam int NW    = 5;
  localparam int XLEN  = 32;
  localparam int IDW   = 3;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, flush, in_valid, in_ready, rf_we, rf_ready, done_valid, busy;
  logic [IDW-1:0]       in_id, rf_id, done_id;
  logic [NW*XLEN-1:0]   in_rd;
  logic [NW*5-1:0]      in_rd_addr;
  logic [NW-1:0]        in_port_en;
  logic [4:0]           rf_addr;
  logic [XLEN-1:0]      rf_data;

  rca_wb_serializer #(
    .NUM_WRITE_PORTS(NW),
    .XLEN(XLEN),
    .ID_W(IDW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_rd(in_rd), .in_rd_addr(in_rd_addr), .in_port_en(in_port_en),
    .rf_we(rf_we), .rf_ready(rf_ready), .rf_addr(rf_addr), .rf_data(rf_data),
    .rf_id(rf_id), .done_valid(done_valid), .done_id(done_id), .busy(busy)
  );

  // Reference model: each bundle is reduced to its ordered list of real writes.
  typedef struct packed {
    logic [IDW-1:0]            id;
    logic [NW-1:0][4:0]        a;
    logic [NW-1:0][XLEN-1:0]   d;
    logic [3:0]                n;
    logic [3:0]                idx;
  } bundle_t;

  bundle_t q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  armed = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input bit r, input bit fl, input bit v, input logic [IDW-1:0] id,
                      input logic [NW*XLEN-1:0] rd, input logic [NW*5-1:0] ad,
                      input logic [NW-1:0] en, input bit rdy, input bit zchk,
                      output bit acc);
    bit e_rdy, e_we, e_done;
    logic [4:0] e_a; logic [XLEN-1:0] e_d; logic [IDW-1:0] e_id;
    bundle_t b;
    @(negedge clk);
    rst = r; flush = fl; in_valid = v; in_id = id; in_rd = rd;
    in_rd_addr = ad; in_port_en = en; rf_ready = rdy;
    #1;
    e_rdy = (q.size() < DEPTH) && !fl;
    e_we = 0; e_done = 0; e_a = '0; e_d = '0; e_id = '0;
    if (!r && !fl && q.size() > 0) begin
      e_id = q[0].id;
      if (q[0].idx == q[0].n) e_done = 1;
      else begin
        e_we   = 1;
        e_a    = q[0].a[q[0].idx];
        e_d    = q[0].d[q[0].idx];
        e_done = rdy && (q[0].idx == q[0].n - 1);
      end
    end
    if (armed) begin
      chk("in_ready", 64'(in_ready), 64'(e_rdy));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("rf_we", 64'(rf_we), 64'(e_we));
      chk("done_valid", 64'(done_valid), 64'(e_done));
      if (e_we) begin
        chk("rf_addr", 64'(rf_addr), 64'(e_a));
        chk("rf_data", 64'(rf_data), 64'(e_d));
        chk("rf_id", 64'(rf_id), 64'(e_id));
      end
      if (e_done) chk("done_id", 64'(done_id), 64'(e_id));
      if (zchk) begin
        chk("rst_rf_addr", 64'(rf_addr), 64'd0);
        chk("rst_rf_data", 64'(rf_data), 64'd0);
        chk("rst_rf_id", 64'(rf_id), 64'd0);
        chk("rst_done_id", 64'(done_id), 64'd0);
      end
    end
    acc = v && e_rdy;
    @(posedge clk);
    if (r || fl) begin
      q.delete();
      if (r) armed = 1'b1;
    end else begin
      if (e_we && rdy) q[0].idx = q[0].idx + 1;
      if (e_done) void'(q.pop_front());
      if (v && e_rdy) begin
        b = '0;
        b.id = id;
        for (int i = 0; i < NW; i++)
          if (en[i] && ad[i*5 +: 5] != 5'd0) begin
            b.a[b.n] = ad[i*5 +: 5];
            b.d[b.n] = rd[i*XLEN +: XLEN];
            b.n = b.n + 1;
          end
        q.push_back(b);
      end
    end
  endtask

  logic [NW*XLEN-1:0] rd;
  logic [NW*5-1:0]    ad;
  bit acc;

  task automatic idle(input int cycles, input bit rdy);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, '0, '0, '0, '0, rdy, 0, acc);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_id = '0; in_rd = '0; in_rd_addr = '0;
    in_port_en = '0; rf_ready = 0;
    step(1, 0, 0, '0, '0, '0, '0, 0, 0, acc);
    step(1, 0, 0, '0, '0, '0, '0, 0, 0, acc);
    step(0, 0, 0, '0, '0, '0, '0, 1, 1, acc);

    // Single bundle: p1->x5, p2->x6, p4->x7
    rd = '0; ad = '0;
    ad[1*5 +: 5] = 5'd5; rd[1*XLEN +: XLEN] = 32'h11;
    ad[2*5 +: 5] = 5'd6; rd[2*XLEN +: XLEN] = 32'h22;
    ad[4*5 +: 5] = 5'd7; rd[4*XLEN +: XLEN] = 32'h44;
    step(0, 0, 1, 3'd3, rd, ad, 5'b10110, 1, 0, acc);
    idle(4, 1);

    // x0-only bundle retires in one cycle without writes
    step(0, 0, 1, 3'd2, '0, '0, 5'b00011, 1, 0, acc);
    idle(2, 1);

    // Backpressure mid-bundle
    step(0, 0, 1, 3'd4, rd, ad, 5'b10110, 1, 0, acc);
    step(0, 0, 0, '0, '0, '0, '0, 1, 0, acc);
    idle(4, 0);
    idle(3, 1);

    // Full FIFO: three 2-write bundles with rf_ready low
    rd = '0; ad = '0;
    ad[0*5 +: 5] = 5'd1; rd[0*XLEN +: XLEN] = 32'hA0;
    ad[3*5 +: 5] = 5'd2; rd[3*XLEN +: XLEN] = 32'hA3;
    for (int k = 0; k < 3; k++) begin
      acc = 0;
      for (int t = 0; t < 20 && !acc; t++)
        step(0, 0, 1, IDW'(5 + k), rd ^ {NW{32'(k)}}, ad, 5'b01001, (t >= 3), 0, acc);
      chk("full_accept", 64'(acc), 64'd1);
    end
    idle(8, 1);

    // Flush after one of three writes
    rd = '0; ad = '0;
    ad[0*5 +: 5] = 5'd10; ad[1*5 +: 5] = 5'd11; ad[2*5 +: 5] = 5'd12;
    rd[0*XLEN +: XLEN] = 32'h1; rd[1*XLEN +: XLEN] = 32'h2; rd[2*XLEN +: XLEN] = 32'h3;
    step(0, 0, 1, 3'd1, rd, ad, 5'b00111, 1, 0, acc);
    step(0, 0, 0, '0, '0, '0, '0, 1, 0, acc);
    step(0, 1, 1, 3'd6, rd, ad, 5'b00111, 1, 0, acc);
    idle(2, 1);

    // Reset precedence, then duplicate addresses (p0 and p3 to x9)
    step(0, 0, 1, 3'd7, rd, ad, 5'b00111, 0, 0, acc);
    step(1, 0, 1, 3'd5, rd, ad, 5'b00111, 1, 0, acc);
    step(0, 0, 0, '0, '0, '0, '0, 1, 1, acc);
    rd = '0; ad = '0;
    ad[0*5 +: 5] = 5'd9; rd[0*XLEN +: XLEN] = 32'hDEAD0000;
    ad[3*5 +: 5] = 5'd9; rd[3*XLEN +: XLEN] = 32'h0000BEEF;
    step(0, 0, 1, 3'd4, rd, ad, 5'b01001, 1, 0, acc);
    idle(3, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NW; i++) begin
        rd[i*XLEN +: XLEN] = $urandom;
        ad[i*5 +: 5] = 5'($urandom_range(0, 7));
      end
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 1) == 1), IDW'($urandom), rd, ad, NW'($urandom),
           ($urandom_range(0, 3) != 0), 0, acc);
    end
    idle(12, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rca_wb_serializer.md
Name: rca_wb_serializer

Overview:
- Sits directly downstream of the RCA unit's writeback output (id, done, rd[NUM_WRITE_PORTS]).
- Buffers completed RCA use-instruction result bundles and drains each bundle into the CPU register file, one register write per cycle.
- Issues a single completion notification per bundle once its last write is accepted.
- Decouples the multi-result RCA writeback from the single register-file write port.

Parameters:
- NUM_WRITE_PORTS, 5, result ports per RCA bundle.
- XLEN, 32, data width.
- ID_W, 3, instruction id width (id_t).
- DEPTH, 2, bundle FIFO entries; must be a power of two and >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all buffered bundles (RCA FIFO clear).
- in_valid  in  1  bundle offered.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- in_id  in  ID_W  instruction id.
- in_rd  in  NUM_WRITE_PORTS*XLEN  result data; port i occupies bits [i*XLEN +: XLEN].
- in_rd_addr  in  NUM_WRITE_PORTS*5  destination register; port i occupies bits [i*5 +: 5].
- in_port_en  in  NUM_WRITE_PORTS  port i carries a valid result.
- rf_we  out  1  register write request.
- rf_ready  in  1  register file accepts the write this cycle.
- rf_addr  out  5  write address.
- rf_data  out  XLEN  write data.
- rf_id  out  ID_W  id of the instruction being written.
- done_valid  out  1  one-cycle pulse: head bundle retired.
- done_id  out  ID_W  id of the retired bundle.
- busy  out  1  FIFO non-empty.

Behaviour:
- Storage: circular FIFO of DEPTH bundles; read pointer, write pointer, and count, with count range 0..DEPTH.
- Per-entry fields: id, data, addr, pending mask.
- Enqueue:
  - in_ready = (count < DEPTH) && !flush. No same-cycle bypass when full.
  - On accept, pending mask = in_port_en & ~(addr==0 per port). Writes to x0 are dropped at enqueue.
- Latency: a bundle accepted in cycle N can drive rf_we no earlier than cycle N+1.
- Head drain (combinational from the head entry when count > 0):
  - Selected port = lowest set bit of the head pending mask.
  - rf_we = 1 when the mask is non-zero; rf_addr, rf_data, rf_id come from the selected port and the head entry.
  - When rf_we && rf_ready, clear that pending bit at the clock edge.
  - When rf_ready = 0, hold all rf_* outputs stable.
- Retire:
  - done_valid = 1 in the cycle the last pending bit is written (rf_we && rf_ready && popcount(mask)==1).
  - done_valid = 1 in any cycle the head mask is zero; this does not wait for rf_ready and sets rf_we = 0.
  - On retire, pop the head at the edge; done_id = head id.
  - Throughput: k writes take k cycles; an empty-mask bundle takes 1 cycle.
- Duplicate addresses within a bundle: written in ascending port order, so the higher port wins.
- Simultaneous enqueue and retire: count unchanged, both pointers advance.
- Wrap-around: pointers are modulo DEPTH.
- flush: at the edge, count=0 and pointers=0.
  - In a flush cycle, rf_we = 0 and done_valid = 0 combinationally, and in_ready = 0.
  - Any partially drained bundle is discarded without a done pulse.
- Reset: same effect as flush, with rst taking priority over every event.
  - After reset: in_ready=1, rf_we=0, done_valid=0, busy=0, rf_addr/rf_data/rf_id/done_id = 0.
- Invariant: rf_we and done_valid are never asserted while count = 0.

Test Plan:
1. Single bundle:
   - Stimulus: id=3, port_en=5'b10110, addr={p1:x5, p2:x6, p4:x7}, data p1=0x11, p2=0x22, p4=0x44, rf_ready=1.
   - Required: writes x5=0x11, x6=0x22, x7=0x44 in consecutive cycles N+1..N+3; done_valid with id 3 in cycle N+3 only.
2. x0 filtering and empty bundle:
   - Stimulus: port_en=5'b00011 with both addresses x0, id=2.
   - Required: no rf_we; done_valid with id 2 in cycle N+1.
3. Backpressure:
   - Stimulus: rf_ready held 0 for 4 cycles mid-bundle.
   - Required: rf_addr/rf_data stable throughout; the remaining writes resume in order; no lost or duplicate writes.
4. Full FIFO:
   - Stimulus: offer 3 back-to-back bundles, each with 2 writes, rf_ready=0.
   - Required: in_ready=0 after 2 accepts; the third bundle is accepted the cycle after the first retires; done ids come out in order across pointer wrap.
5. Flush mid-drain:
   - Stimulus: assert flush after 1 of 3 writes.
   - Required: no further rf_we, no done pulse for that bundle; busy=0 and in_ready=1 the next cycle.
6. Reset precedence:
   - Stimulus: rst asserted together with in_valid and rf_ready.
   - Required: nothing enqueued; all outputs at reset values next cycle; duplicate-address case (p0 and p3 both to x9) then shows the p3 value written last.
